// File: rtl/memaccess_lsu.sv
// Memory-access pipeline stage: issues load/store requests on a req/gnt/rvalid data bus,
// aligns load data and registers the instruction, PC and result into the writeback stage.
module memaccess_lsu (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ma_inst,
   input  logic [31:0] ma_pc,
   input  logic [31:0] ma_dat,
   input  logic [31:0] ma_rd2,
   output logic        ma_stall,
   output logic        ma_misalign,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_gnt,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] wb_inst,
   output logic [31:0] wb_pc,
   output logic [31:0] wb_dat,
   output logic        wb_fwd_we,
   output logic [4:0]  wb_fwd_dst,
   output logic [31:0] wb_fwd_dat
);

   localparam logic [6:0]  OpLoad   = 7'b0000011;
   localparam logic [6:0]  OpStore  = 7'b0100011;
   localparam logic [6:0]  OpBranch = 7'b1100011;
   localparam logic [31:0] Bubble   = 32'h0000_0013;

   typedef enum logic [1:0] {StIdle, StReq, StRdWait} state_e;

   state_e      state_q, state_d;
   logic [31:0] wb_inst_q, wb_inst_d;
   logic [31:0] wb_pc_q, wb_pc_d;
   logic [31:0] wb_dat_q, wb_dat_d;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [1:0]  size;
   logic        is_load, is_store, is_mem, misaligned;
   logic [31:0] rdata_shifted, load_data;

   assign opcode   = ma_inst[6:0];
   assign funct3   = ma_inst[14:12];
   assign size     = funct3[1:0];
   assign is_load  = (opcode == OpLoad);
   assign is_store = (opcode == OpStore);
   assign is_mem   = is_load || is_store;

   always_comb begin
      misaligned = 1'b0;
      if (is_mem) begin
         if (size == 2'b01) misaligned = ma_dat[0];
         else if (size[1]) misaligned = |ma_dat[1:0];
      end
   end

   // Address and data are derived straight from ma_*, which upstream holds while stalled.
   assign dmem_we   = is_store;
   assign dmem_addr = {ma_dat[31:2], 2'b00};

   always_comb begin
      dmem_be    = 4'b1111;
      dmem_wdata = ma_rd2;
      case (size)
         2'b00: begin
            dmem_be    = 4'b0001 << ma_dat[1:0];
            dmem_wdata = {4{ma_rd2[7:0]}};
         end
         2'b01: begin
            dmem_be    = 4'b0011 << ma_dat[1:0];
            dmem_wdata = {2{ma_rd2[15:0]}};
         end
         default: ;
      endcase
   end

   assign rdata_shifted = dmem_rdata >> {ma_dat[1:0], 3'b000};

   always_comb begin
      load_data = dmem_rdata;
      case (funct3)
         3'b000:  load_data = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
         3'b001:  load_data = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
         3'b100:  load_data = {24'h0, rdata_shifted[7:0]};
         3'b101:  load_data = {16'h0, rdata_shifted[15:0]};
         default: load_data = dmem_rdata;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      wb_inst_d   = Bubble;
      wb_pc_d     = wb_pc_q;
      wb_dat_d    = wb_dat_q;
      dmem_req    = 1'b0;
      ma_stall    = 1'b0;
      ma_misalign = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (is_mem && misaligned) begin
               ma_misalign = 1'b1;
               wb_pc_d     = ma_pc;
               wb_dat_d    = ma_dat;
            end else if (is_mem) begin
               dmem_req = 1'b1;
               if (dmem_gnt && is_store) begin
                  wb_inst_d = ma_inst;
                  wb_pc_d   = ma_pc;
                  wb_dat_d  = ma_dat;
               end else begin
                  ma_stall = 1'b1;
                  state_d  = dmem_gnt ? StRdWait : StReq;
               end
            end else begin
               wb_inst_d = ma_inst;
               wb_pc_d   = ma_pc;
               wb_dat_d  = ma_dat;
            end
         end
         StReq: begin
            dmem_req = 1'b1;
            if (dmem_gnt && is_store) begin
               wb_inst_d = ma_inst;
               wb_pc_d   = ma_pc;
               wb_dat_d  = ma_dat;
               state_d   = StIdle;
            end else begin
               ma_stall = 1'b1;
               if (dmem_gnt) state_d = StRdWait;
            end
         end
         StRdWait: begin
            if (dmem_rvalid) begin
               wb_inst_d = ma_inst;
               wb_pc_d   = ma_pc;
               wb_dat_d  = load_data;
               state_d   = StIdle;
            end else begin
               ma_stall = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
      // Outputs are forced quiet for the whole reset cycle, not just after the edge.
      if (rst) begin
         dmem_req    = 1'b0;
         ma_stall    = 1'b0;
         ma_misalign = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         wb_inst_q <= Bubble;
         wb_pc_q   <= 32'h0;
         wb_dat_q  <= 32'h0;
      end else begin
         state_q   <= state_d;
         wb_inst_q <= wb_inst_d;
         wb_pc_q   <= wb_pc_d;
         wb_dat_q  <= wb_dat_d;
      end
   end

   assign wb_inst    = wb_inst_q;
   assign wb_pc      = wb_pc_q;
   assign wb_dat     = wb_dat_q;
   assign wb_fwd_dst = wb_inst_q[11:7];
   assign wb_fwd_dat = wb_dat_q;
   assign wb_fwd_we  = !rst && (wb_inst_q[6:0] != OpStore) && (wb_inst_q[6:0] != OpBranch)
                       && (wb_inst_q[11:7] != 5'd0);

endmodule

// File: tb/tb_memaccess_lsu.sv
// Directed bench for memaccess_lsu: ALU pass-through, loads, delayed-grant store,
// misalignment, reset mid-load and back-to-back memory ops.
module tb_memaccess_lsu;

   localparam logic [31:0] Bubble  = 32'h0000_0013;
   localparam logic [31:0] InstAdd = 32'h0000_02B3;  // add x5, x0, x0
   localparam logic [31:0] InstLb  = 32'h0000_0183;  // lb  x3
   localparam logic [31:0] InstLbu = 32'h0000_4183;  // lbu x3
   localparam logic [31:0] InstSh  = 32'h0000_1023;
   localparam logic [31:0] InstLw  = 32'h0000_2083;  // lw  x1
   localparam logic [31:0] InstSw  = 32'h0000_2023;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ma_inst, ma_pc, ma_dat, ma_rd2;
   logic        ma_stall, ma_misalign;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_gnt, dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic [31:0] wb_inst, wb_pc, wb_dat, wb_fwd_dat;
   logic        wb_fwd_we;
   logic [4:0]  wb_fwd_dst;

   int n_vec = 0;
   int n_err = 0;

   memaccess_lsu dut (
      .clk         (clk),
      .rst         (rst),
      .ma_inst     (ma_inst),
      .ma_pc       (ma_pc),
      .ma_dat      (ma_dat),
      .ma_rd2      (ma_rd2),
      .ma_stall    (ma_stall),
      .ma_misalign (ma_misalign),
      .dmem_req    (dmem_req),
      .dmem_we     (dmem_we),
      .dmem_addr   (dmem_addr),
      .dmem_be     (dmem_be),
      .dmem_wdata  (dmem_wdata),
      .dmem_gnt    (dmem_gnt),
      .dmem_rvalid (dmem_rvalid),
      .dmem_rdata  (dmem_rdata),
      .wb_inst     (wb_inst),
      .wb_pc       (wb_pc),
      .wb_dat      (wb_dat),
      .wb_fwd_we   (wb_fwd_we),
      .wb_fwd_dst  (wb_fwd_dst),
      .wb_fwd_dat  (wb_fwd_dat)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Grant in the issue cycle, rvalid on the third cycle after it.
   task automatic run_load(input string tag, input logic [31:0] inst, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp_dat,
                           input logic [3:0] exp_be);
      int stalls;
      stalls   = 0;
      ma_inst  = inst;
      ma_dat   = addr;
      ma_pc    = 32'h44;
      dmem_gnt = 1'b1;
      @(negedge clk);
      check_val({tag, "_req"}, 32'(dmem_req), 1);
      check_val({tag, "_we"}, 32'(dmem_we), 0);
      check_val({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
      check_val({tag, "_be"}, 32'(dmem_be), 32'(exp_be));
      stalls += int'(ma_stall);
      tick();
      dmem_gnt = 1'b0;
      check_val({tag, "_bubble"}, wb_inst, Bubble);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check_val({tag, "_noreq"}, 32'(dmem_req), 0);
         stalls += int'(ma_stall);
         tick();
      end
      dmem_rvalid = 1'b1;
      dmem_rdata  = rdata;
      @(negedge clk);
      check_val({tag, "_stall_done"}, 32'(ma_stall), 0);
      tick();
      dmem_rvalid = 1'b0;
      check_val({tag, "_dat"}, wb_dat, exp_dat);
      check_val({tag, "_inst"}, wb_inst, inst);
      check_val({tag, "_fwd_we"}, 32'(wb_fwd_we), 1);
      check_val({tag, "_stalls"}, 32'(stalls), 3);
      ma_inst = Bubble;
      ma_dat  = 32'h0;
   endtask

   initial begin
      rst         = 1'b1;
      ma_inst     = InstLw;
      ma_pc       = 32'h0;
      ma_dat      = 32'h0;
      ma_rd2      = 32'h0;
      dmem_gnt    = 1'b1;
      dmem_rvalid = 1'b0;
      dmem_rdata  = 32'h0;

      // Reset: an aligned load is presented but must not issue.
      tick();
      tick();
      @(negedge clk);
      check_val("rst_req", 32'(dmem_req), 0);
      check_val("rst_stall", 32'(ma_stall), 0);
      check_val("rst_misalign", 32'(ma_misalign), 0);
      check_val("rst_fwd_we", 32'(wb_fwd_we), 0);
      tick();
      check_val("rst_wb_inst", wb_inst, Bubble);
      check_val("rst_wb_pc", wb_pc, 0);
      check_val("rst_wb_dat", wb_dat, 0);
      rst      = 1'b0;
      dmem_gnt = 1'b0;
      ma_inst  = Bubble;

      // ALU instruction passes through in one cycle.
      ma_inst = InstAdd;
      ma_pc   = 32'h40;
      ma_dat  = 32'h1234;
      @(negedge clk);
      check_val("add_stall", 32'(ma_stall), 0);
      check_val("add_req", 32'(dmem_req), 0);
      tick();
      check_val("add_wb_dat", wb_dat, 32'h1234);
      check_val("add_wb_inst", wb_inst, InstAdd);
      check_val("add_wb_pc", wb_pc, 32'h40);
      check_val("add_fwd_we", 32'(wb_fwd_we), 1);
      check_val("add_fwd_dst", 32'(wb_fwd_dst), 5);
      check_val("add_fwd_dat", wb_fwd_dat, 32'h1234);
      ma_inst = Bubble;
      ma_dat  = 32'h0;

      run_load("lb", InstLb, 32'h103, 32'h80FF_FFFF, 32'hFFFF_FF80, 4'b1000);
      run_load("lbu", InstLbu, 32'h103, 32'h80FF_FFFF, 32'h0000_0080, 4'b1000);

      // SH with grant on the fourth request cycle; a stray rvalid is thrown in.
      ma_inst = InstSh;
      ma_pc   = 32'h50;
      ma_dat  = 32'h202;
      ma_rd2  = 32'hABCD_1234;
      for (int i = 0; i < 4; i++) begin
         dmem_gnt    = (i == 3);
         dmem_rvalid = (i == 1);
         @(negedge clk);
         check_val("sh_req", 32'(dmem_req), 1);
         check_val("sh_we", 32'(dmem_we), 1);
         check_val("sh_addr", dmem_addr, 32'h200);
         check_val("sh_be", 32'(dmem_be), 32'hC);
         check_val("sh_wdata", dmem_wdata, 32'h1234_1234);
         check_val("sh_stall", 32'(ma_stall), (i == 3) ? 0 : 1);
         tick();
         if (i < 3) check_val("sh_bubble", wb_inst, Bubble);
      end
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      check_val("sh_wb_inst", wb_inst, InstSh);
      check_val("sh_fwd_we", 32'(wb_fwd_we), 0);
      ma_inst = Bubble;
      ma_dat  = 32'h0;
      ma_rd2  = 32'h0;
      @(negedge clk);
      check_val("sh_req_drop", 32'(dmem_req), 0);
      tick();

      // Misaligned LW.
      ma_inst = InstLw;
      ma_dat  = 32'h101;
      @(negedge clk);
      check_val("mis_req", 32'(dmem_req), 0);
      check_val("mis_pulse", 32'(ma_misalign), 1);
      check_val("mis_stall", 32'(ma_stall), 0);
      tick();
      check_val("mis_wb_inst", wb_inst, Bubble);
      ma_inst = Bubble;
      ma_dat  = 32'h0;
      @(negedge clk);
      check_val("mis_pulse_end", 32'(ma_misalign), 0);
      tick();

      // Reset while waiting for read data; the late rvalid must be dropped.
      ma_inst  = InstLw;
      ma_dat   = 32'h300;
      dmem_gnt = 1'b1;
      tick();
      dmem_gnt = 1'b0;
      rst      = 1'b1;
      tick();
      rst         = 1'b0;
      ma_inst     = Bubble;
      ma_dat      = 32'h0;
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'hDEAD_BEEF;
      @(negedge clk);
      check_val("rstw_stall", 32'(ma_stall), 0);
      check_val("rstw_req", 32'(dmem_req), 0);
      tick();
      dmem_rvalid = 1'b0;
      check_val("rstw_wb_inst", wb_inst, Bubble);
      check_val("rstw_wb_dat", wb_dat, 0);

      // LW then SW back to back, single-cycle grant and rvalid.
      ma_inst  = InstLw;
      ma_pc    = 32'h60;
      ma_dat   = 32'h400;
      dmem_gnt = 1'b1;
      @(negedge clk);
      check_val("b2b_ld_req", 32'(dmem_req), 1);
      tick();
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'h1122_3344;
      @(negedge clk);
      check_val("b2b_cmpl_req", 32'(dmem_req), 0);
      check_val("b2b_cmpl_stall", 32'(ma_stall), 0);
      tick();
      dmem_rvalid = 1'b0;
      check_val("b2b_ld_dat", wb_dat, 32'h1122_3344);
      ma_inst  = InstSw;
      ma_pc    = 32'h64;
      ma_dat   = 32'h404;
      ma_rd2   = 32'h55;
      dmem_gnt = 1'b1;
      @(negedge clk);
      check_val("b2b_st_req", 32'(dmem_req), 1);
      check_val("b2b_st_we", 32'(dmem_we), 1);
      check_val("b2b_st_be", 32'(dmem_be), 32'hF);
      check_val("b2b_st_wdata", dmem_wdata, 32'h55);
      check_val("b2b_st_stall", 32'(ma_stall), 0);
      tick();
      dmem_gnt = 1'b0;
      check_val("b2b_st_wb_inst", wb_inst, InstSw);
      ma_inst = Bubble;
      @(negedge clk);
      check_val("b2b_idle_req", 32'(dmem_req), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
